// File: rtl/execute_stage_pkg.sv
// Shared encodings for the execute stage: ALU op codes, funct codes,
// control-field bit positions and the EX/MEM register layout.
package execute_stage_pkg;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_e;

    typedef enum logic [5:0] {
        FUNCT_ADD = 6'b100000,
        FUNCT_SUB = 6'b100010,
        FUNCT_AND = 6'b100100,
        FUNCT_OR  = 6'b100101,
        FUNCT_SLT = 6'b101010
    } funct_e;

    // ALU_ZERO covers the reserved aluop and unrecognised funct codes.
    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_ZERO = 4'b1111
    } alu_op_e;

    localparam int unsigned EX_REGDST   = 3;
    localparam int unsigned EX_ALUOP_HI = 2;
    localparam int unsigned EX_ALUOP_LO = 1;
    localparam int unsigned EX_ALUSRC   = 0;

    localparam int unsigned WB_MEMTOREG = 1;
    localparam int unsigned WB_REGWRITE = 0;

    localparam int unsigned MEM_BRANCH   = 2;
    localparam int unsigned MEM_MEMREAD  = 1;
    localparam int unsigned MEM_MEMWRITE = 0;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [31:0] add_result;
        logic        zero;
        logic [31:0] alu_result;
        logic [31:0] readdat2;
        logic [4:0]  write_reg;
    } ex_mem_t;

endpackage

// File: rtl/execute_stage_ex_mem_latch.sv
// EX/MEM pipeline register with synchronous reset, bubble insertion and stall.
module ex_mem_latch
    import execute_stage_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    flush_i,
    input  logic    hold_i,
    input  ex_mem_t ex_mem_i,
    output ex_mem_t ex_mem_o
);

    ex_mem_t ex_mem_d, ex_mem_q;

    // Flush outranks hold: a flushed edge always loads, with control zeroed.
    always_comb begin
        ex_mem_d = ex_mem_q;
        if (flush_i) begin
            ex_mem_d    = ex_mem_i;
            ex_mem_d.wb = '0;
            ex_mem_d.m  = '0;
        end else if (!hold_i) begin
            ex_mem_d = ex_mem_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ex_mem_q <= '0;
        else     ex_mem_q <= ex_mem_d;
    end

    assign ex_mem_o = ex_mem_q;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU control, ALU, branch target adder and destination mux,
// registered into the EX/MEM latch.
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  id_ex_wb,
    input  logic [2:0]  id_ex_mem,
    input  logic [3:0]  id_ex_execute,
    input  logic [31:0] id_ex_npc,
    input  logic [31:0] id_ex_readdat1,
    input  logic [31:0] id_ex_readdat2,
    input  logic [31:0] id_ex_sign_ext,
    input  logic [4:0]  id_ex_instr_bits_20_16,
    input  logic [4:0]  id_ex_instr_bits_15_11,
    input  logic        ex_flush,
    input  logic        ex_hold,
    output logic [1:0]  ex_mem_wb,
    output logic [2:0]  ex_mem_m,
    output logic [31:0] ex_mem_add_result,
    output logic        ex_mem_zero,
    output logic [31:0] ex_mem_alu_result,
    output logic [31:0] ex_mem_readdat2,
    output logic [4:0]  ex_mem_write_reg
);

    aluop_e      aluop;
    logic [5:0]  funct;
    alu_op_e     alu_ctl;
    logic [31:0] op_a, op_b, alu_res;
    ex_mem_t     ex_mem_in, ex_mem_out;

    assign aluop = aluop_e'(id_ex_execute[EX_ALUOP_HI:EX_ALUOP_LO]);
    assign funct = id_ex_sign_ext[5:0];
    assign op_a  = id_ex_readdat1;
    assign op_b  = id_ex_execute[EX_ALUSRC] ? id_ex_sign_ext : id_ex_readdat2;

    always_comb begin
        alu_ctl = ALU_ZERO;
        case (aluop)
            ALUOP_ADD:   alu_ctl = ALU_ADD;
            ALUOP_SUB:   alu_ctl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_ctl = ALU_ADD;
                    FUNCT_SUB: alu_ctl = ALU_SUB;
                    FUNCT_AND: alu_ctl = ALU_AND;
                    FUNCT_OR:  alu_ctl = ALU_OR;
                    FUNCT_SLT: alu_ctl = ALU_SLT;
                    default:   alu_ctl = ALU_ZERO;
                endcase
            end
            default:     alu_ctl = ALU_ZERO;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (alu_ctl)
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_ADD: alu_res = op_a + op_b;
            ALU_SUB: alu_res = op_a - op_b;
            ALU_SLT: alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        ex_mem_in.wb         = id_ex_wb;
        ex_mem_in.m          = id_ex_mem;
        ex_mem_in.add_result = id_ex_npc + {id_ex_sign_ext[29:0], 2'b00};
        ex_mem_in.zero       = (alu_res == '0);
        ex_mem_in.alu_result = alu_res;
        ex_mem_in.readdat2   = id_ex_readdat2;
        ex_mem_in.write_reg  = id_ex_execute[EX_REGDST] ? id_ex_instr_bits_15_11
                                                        : id_ex_instr_bits_20_16;
    end

    ex_mem_latch u_ex_mem_latch (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (ex_flush),
        .hold_i   (ex_hold),
        .ex_mem_i (ex_mem_in),
        .ex_mem_o (ex_mem_out)
    );

    assign ex_mem_wb         = ex_mem_out.wb;
    assign ex_mem_m          = ex_mem_out.m;
    assign ex_mem_add_result = ex_mem_out.add_result;
    assign ex_mem_zero       = ex_mem_out.zero;
    assign ex_mem_alu_result = ex_mem_out.alu_result;
    assign ex_mem_readdat2   = ex_mem_out.readdat2;
    assign ex_mem_write_reg  = ex_mem_out.write_reg;

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage with hand-computed vectors.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  id_ex_wb;
    logic [2:0]  id_ex_mem;
    logic [3:0]  id_ex_execute;
    logic [31:0] id_ex_npc, id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext;
    logic [4:0]  id_ex_instr_bits_20_16, id_ex_instr_bits_15_11;
    logic        ex_flush, ex_hold;
    logic [1:0]  ex_mem_wb;
    logic [2:0]  ex_mem_m;
    logic [31:0] ex_mem_add_result, ex_mem_alu_result, ex_mem_readdat2;
    logic        ex_mem_zero;
    logic [4:0]  ex_mem_write_reg;

    int checks   = 0;
    int failures = 0;

    execute_stage dut (
        .clk                    (clk),
        .rst                    (rst),
        .id_ex_wb               (id_ex_wb),
        .id_ex_mem              (id_ex_mem),
        .id_ex_execute          (id_ex_execute),
        .id_ex_npc              (id_ex_npc),
        .id_ex_readdat1         (id_ex_readdat1),
        .id_ex_readdat2         (id_ex_readdat2),
        .id_ex_sign_ext         (id_ex_sign_ext),
        .id_ex_instr_bits_20_16 (id_ex_instr_bits_20_16),
        .id_ex_instr_bits_15_11 (id_ex_instr_bits_15_11),
        .ex_flush               (ex_flush),
        .ex_hold                (ex_hold),
        .ex_mem_wb              (ex_mem_wb),
        .ex_mem_m               (ex_mem_m),
        .ex_mem_add_result      (ex_mem_add_result),
        .ex_mem_zero            (ex_mem_zero),
        .ex_mem_alu_result      (ex_mem_alu_result),
        .ex_mem_readdat2        (ex_mem_readdat2),
        .ex_mem_write_reg       (ex_mem_write_reg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] wb, input logic [2:0] m,
                           input logic [31:0] add, input logic zero, input logic [31:0] alu,
                           input logic [31:0] rd2, input logic [4:0] wreg);
        chk({tag, ".wb"},   {30'd0, ex_mem_wb}, {30'd0, wb});
        chk({tag, ".m"},    {29'd0, ex_mem_m}, {29'd0, m});
        chk({tag, ".add"},  ex_mem_add_result, add);
        chk({tag, ".zero"}, {31'd0, ex_mem_zero}, {31'd0, zero});
        chk({tag, ".alu"},  ex_mem_alu_result, alu);
        chk({tag, ".rd2"},  ex_mem_readdat2, rd2);
        chk({tag, ".wreg"}, {27'd0, ex_mem_write_reg}, {27'd0, wreg});
    endtask

    task automatic drive(input logic [1:0] wb, input logic [2:0] mem, input logic [3:0] ex,
                         input logic [31:0] npc, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] se, input logic [4:0] rt, input logic [4:0] rd);
        id_ex_wb               = wb;
        id_ex_mem              = mem;
        id_ex_execute          = ex;
        id_ex_npc              = npc;
        id_ex_readdat1         = r1;
        id_ex_readdat2         = r2;
        id_ex_sign_ext         = se;
        id_ex_instr_bits_20_16 = rt;
        id_ex_instr_bits_15_11 = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ex_flush = 1'b0; ex_hold = 1'b1;
        drive(2'b11, 3'b111, 4'b1100, 32'h40, 32'd5, 32'd7, 32'h20, 5'd9, 5'd3);
        @(negedge clk);
        tick();
        chk_all("reset", 2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);

        // R-type ADD
        rst = 1'b0; ex_hold = 1'b0;
        drive(2'b01, 3'b000, 4'b1100, 32'h40, 32'd5, 32'd7, 32'h20, 5'd9, 5'd3);
        #2;
        chk("latency.alu", ex_mem_alu_result, 32'h0);
        tick();
        chk_all("add", 2'b01, 3'b000, 32'hC0, 1'b0, 32'd12, 32'd7, 5'd3);

        // R-type SUB giving zero
        drive(2'b01, 3'b000, 4'b1100, 32'h0, 32'd7, 32'd7, 32'h22, 5'd1, 5'd4);
        tick();
        chk("sub.alu", ex_mem_alu_result, 32'h0);
        chk("sub.zero", {31'd0, ex_mem_zero}, 32'd1);
        chk("sub.add", ex_mem_add_result, 32'h88);

        // AND / OR
        drive(2'b01, 3'b000, 4'b1100, 32'h0, 32'h0000F0F0, 32'h00000FF0, 32'h24, 5'd1, 5'd5);
        tick();
        chk("and.alu", ex_mem_alu_result, 32'h000000F0);
        drive(2'b01, 3'b000, 4'b1100, 32'h0, 32'h0000F0F0, 32'h00000FF0, 32'h25, 5'd1, 5'd5);
        tick();
        chk("or.alu", ex_mem_alu_result, 32'h0000FFF0);

        // LW: immediate operand, rt destination
        drive(2'b11, 3'b010, 4'b0001, 32'h100, 32'h100, 32'h55, 32'hFFFFFFFC, 5'd2, 5'd7);
        tick();
        chk_all("lw", 2'b11, 3'b010, 32'hF0, 1'b0, 32'hFC, 32'h55, 5'd2);

        // aluop 01 SUB wraps
        drive(2'b00, 3'b000, 4'b0010, 32'h0, 32'd3, 32'd5, 32'h0, 5'd1, 5'd2);
        tick();
        chk("subwrap.alu", ex_mem_alu_result, 32'hFFFFFFFE);
        chk("subwrap.zero", {31'd0, ex_mem_zero}, 32'd0);

        // aluop 11 reserved and unknown funct both give 0
        drive(2'b01, 3'b000, 4'b0110, 32'h0, 32'd3, 32'd5, 32'h20, 5'd1, 5'd2);
        tick();
        chk("rsvd.alu", ex_mem_alu_result, 32'h0);
        chk("rsvd.zero", {31'd0, ex_mem_zero}, 32'd1);
        drive(2'b01, 3'b000, 4'b1100, 32'h0, 32'd3, 32'd5, 32'h27, 5'd1, 5'd2);
        tick();
        chk("badfunct.alu", ex_mem_alu_result, 32'h0);

        // SLT signed, both orders
        drive(2'b01, 3'b000, 4'b1100, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h2A, 5'd1, 5'd6);
        tick();
        chk("slt.alu", ex_mem_alu_result, 32'd1);
        drive(2'b01, 3'b000, 4'b1100, 32'h0, 32'd1, 32'hFFFFFFFF, 32'h2A, 5'd1, 5'd6);
        tick();
        chk("sltswap.alu", ex_mem_alu_result, 32'd0);

        // BEQ: funct field 000011 is unrecognised, so the result is 0
        drive(2'b00, 3'b100, 4'b0100, 32'h20, 32'd9, 32'd9, 32'd3, 5'd4, 5'd8);
        tick();
        chk_all("beq", 2'b00, 3'b100, 32'h2C, 1'b1, 32'h0, 32'd9, 5'd4);

        // Flush with hold: bubble control, data loads
        drive(2'b11, 3'b100, 4'b0100, 32'h20, 32'd9, 32'd9, 32'd3, 5'd4, 5'd8);
        ex_flush = 1'b1; ex_hold = 1'b1;
        tick();
        chk_all("flushhold", 2'b00, 3'b000, 32'h2C, 1'b1, 32'h0, 32'd9, 5'd4);

        // Hold alone with new inputs: nothing changes
        ex_flush = 1'b0;
        drive(2'b01, 3'b010, 4'b1100, 32'h40, 32'd5, 32'd7, 32'h20, 5'd9, 5'd3);
        tick();
        chk_all("hold", 2'b00, 3'b000, 32'h2C, 1'b1, 32'h0, 32'd9, 5'd4);

        // Hold released loads the waiting inputs
        ex_hold = 1'b0;
        tick();
        chk_all("release", 2'b01, 3'b010, 32'hC0, 1'b0, 32'd12, 32'd7, 5'd3);

        // Flush alone
        ex_flush = 1'b1;
        drive(2'b10, 3'b001, 4'b0001, 32'h0, 32'd1, 32'd2, 32'd2, 5'd10, 5'd11);
        tick();
        chk_all("flush", 2'b00, 3'b000, 32'h8, 1'b0, 32'd3, 32'd2, 5'd10);
        ex_flush = 1'b0;

        // Reset mid-stream beats hold, then inputs latch on release
        drive(2'b01, 3'b000, 4'b1100, 32'h0, 32'h7FFFFFFF, 32'd1, 32'h20, 5'd1, 5'd12);
        rst = 1'b1; ex_hold = 1'b1;
        tick();
        chk_all("midrst", 2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);
        rst = 1'b0; ex_hold = 1'b0;
        tick();
        chk_all("postrst", 2'b01, 3'b000, 32'h80, 1'b0, 32'h80000000, 32'd1, 5'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 id_ex_wb  input  2  {memtoreg, regwrite} from ID/EX.
REQ-004 id_ex_mem  input  3  {branch, memread, memwrite} from ID/EX.
REQ-005 id_ex_execute  input  4  {regdst, aluop[1:0], alusrc} from ID/EX.
REQ-006 id_ex_npc  input  32  PC+4 of the instruction.
REQ-007 id_ex_readdat1, id_ex_readdat2  input  32 each  rs and rt operands.
REQ-008 id_ex_sign_ext  input  32  sign-extended immediate; bits [5:0] are funct.
REQ-009 id_ex_instr_bits_20_16, id_ex_instr_bits_15_11  input  5 each  rt and rd fields.
REQ-010 ex_flush  input  1  squash the instruction entering EX/MEM (bubble).
REQ-011 ex_hold  input  1  freeze the EX/MEM register (stall).
REQ-012 ex_mem_wb  output  2  latched id_ex_wb.
REQ-013 ex_mem_m  output  3  latched id_ex_mem.
REQ-014 ex_mem_add_result  output  32  latched branch target.
REQ-015 ex_mem_zero  output  1  latched ALU zero flag.
REQ-016 ex_mem_alu_result  output  32  latched ALU result.
REQ-017 ex_mem_readdat2  output  32  latched store data (id_ex_readdat2).
REQ-018 ex_mem_write_reg  output  5  latched destination register.

Function
REQ-019 ALU operand A SHALL be id_ex_readdat1; operand B SHALL be id_ex_sign_ext when alusrc=1, else id_ex_readdat2.
REQ-020 ALU control SHALL be: aluop 00 -> ADD; 01 -> SUB; 10 -> decode funct; 11 -> reserved, result 0.
REQ-021 Funct decode SHALL be: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT; any other funct yields result 0.
REQ-022 ADD/SUB SHALL wrap modulo 2^32 with no overflow flag or exception.
REQ-023 SLT SHALL compare A and B as signed two's-complement and return 32'd1 or 32'd0.
REQ-024 Zero flag SHALL be 1 iff the 32-bit ALU result equals 0.
REQ-025 Branch target SHALL be id_ex_npc + (id_ex_sign_ext << 2), truncated to 32 bits.
REQ-026 Destination SHALL be id_ex_instr_bits_15_11 when regdst=1, else id_ex_instr_bits_20_16.
REQ-027 ALU, ALU control, target adder and destination mux SHALL be combinational; every output SHALL change only at a rising clk edge, giving a latency of exactly 1 cycle.
REQ-028 With rst=0, ex_hold=0 and ex_flush=0, each edge SHALL load all EX/MEM fields from the current-cycle combinational results.
REQ-029 With ex_flush=1 and rst=0, the edge SHALL load ex_mem_wb=00 and ex_mem_m=000, and SHALL load the data fields normally.
REQ-030 With ex_hold=1, ex_flush=0 and rst=0, all EX/MEM fields SHALL retain their values.
REQ-031 Priority SHALL be rst > ex_flush > ex_hold; flush together with hold SHALL still insert a bubble.
REQ-032 Control fields SHALL pass through unmodified except under rst or ex_flush.

Reset
REQ-033 On a rising edge with rst=1, every output SHALL become 0: wb 00, m 000, add_result 0, zero 0, alu_result 0, readdat2 0, write_reg 0.
REQ-034 rst asserted mid-stream SHALL discard the in-flight instruction; the first edge after deassertion SHALL latch the then-current inputs.
REQ-035 The block SHALL contain no initial blocks and no asynchronous logic.

Structure
REQ-036 A shared package SHALL hold the aluop encodings, the funct codes, the 4-bit ALU operation codes (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111) and the control-field bit positions.
REQ-037 The EX/MEM register SHALL be a separate sub-module named ex_mem_latch, implementing rst, flush and hold; the ALU and its control SHALL stay in execute_stage.

Verification
REQ-038 R-type ADD: readdat1=5, readdat2=7, ex=1100, funct=100000, rd=3 -> after 1 edge, alu_result=12, zero=0, write_reg=3, wb=01.
REQ-039 LW: readdat1=0x100, sign_ext=0xFFFFFFFC, ex=0001, rt=2, wb=11, mem=010 -> alu_result=0xFC, write_reg=2, wb=11, m=010.
REQ-040 BEQ: readdat1=readdat2=9, ex=0100, npc=0x20, sign_ext=3 -> zero=1, add_result=0x2C, m=100.
REQ-041 SLT signed: readdat1=0xFFFFFFFF, readdat2=1, funct=101010 -> alu_result=1; operands swapped -> alu_result=0.
REQ-042 Flush during BEQ plus hold: ex_flush=1 and ex_hold=1 on the same edge -> wb=00, m=000; next cycle ex_hold=1 alone -> all outputs unchanged.
REQ-043 Reset mid-stream: rst=1 for one edge while ADD 0x7FFFFFFF+1 is in EX -> all outputs 0; with rst=0 and the same inputs held, the next edge -> alu_result=0x80000000.
